// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] HALT_INSTR_DEF = 32'hFFFF_FFFF;
  localparam int unsigned IMEM_DEPTH_DEF = 1024;

endpackage

// File: rtl/instr_fetch_ctrl.sv
// Sequences a 1-cycle synchronous ROM and presents words to IF/ID over valid/ready.
// Stalls re-read the same ROM word, so if_instr/if_pc stay stable without a skid register.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int unsigned IMEM_DEPTH = IMEM_DEPTH_DEF,
  parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  localparam logic [32:0] DEPTH33 = 33'(IMEM_DEPTH);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic         r_vld;
  logic [31:0]  r_count;

  logic        w_run;
  logic        w_accept;
  logic        w_is_halt;
  logic [32:0] w_pc_inc;
  logic        w_inc_oob;
  logic        w_redir_oob;

  // Bounds checks use 33 bits so pc_q+1 cannot wrap past the limit.
  assign w_pc_inc    = {1'b0, r_pc} + 33'd1;
  assign w_inc_oob   = (w_pc_inc >= DEPTH33);
  assign w_redir_oob = ({1'b0, redirect_pc} >= DEPTH33);

  assign w_run     = (r_state == RUN);
  assign if_valid  = w_run & r_vld & ~redirect_valid;
  assign w_accept  = if_valid & if_ready;
  assign w_is_halt = (imem_rdata == HALT_INSTR);

  assign if_instr    = imem_rdata;
  assign if_pc       = r_pc;
  assign halted      = (r_state == HALT);
  assign fault       = (r_state == FAULT);
  assign fetch_count = r_count;

  always_comb begin
    imem_addr = r_pc;
    case (r_state)
      IDLE: imem_addr = RESET_PC;
      RUN: begin
        if (redirect_valid)             imem_addr = redirect_pc;
        else if (w_accept & ~w_is_halt) imem_addr = w_pc_inc[31:0];
        else                            imem_addr = r_pc;
      end
      default: imem_addr = r_pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_vld   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (fetch_en) begin
            r_state <= RUN;
            r_pc    <= RESET_PC;
            r_vld   <= 1'b1;
          end
        end
        RUN: begin
          if (redirect_valid) begin
            r_pc  <= redirect_pc;
            r_vld <= ~w_redir_oob;
            if (w_redir_oob) r_state <= FAULT;
          end else if (w_accept && w_is_halt) begin
            r_state <= HALT;
            r_vld   <= 1'b0;
          end else if (w_accept) begin
            r_pc <= w_pc_inc[31:0];
            if (w_inc_oob) begin
              r_state <= FAULT;
              r_vld   <= 1'b0;
            end
          end
        end
        HALT: begin
          if (!fetch_en) r_state <= IDLE;
        end
        default: r_state <= FAULT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 32'h0;
    end else if (w_accept && (r_count != 32'hFFFF_FFFF)) begin
      r_count <= r_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a behavioural 1024x32 synchronous ROM.
module tb_instr_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rom [1024];

  instr_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .fault          (fault),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= rom[imem_addr[9:0]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_en = 1'b0; if_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    tick(); tick(); #1;
    n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%0b exp=0", if_valid); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
    n_cmp++; if (fetch_count !== 32'h0) begin n_err++; $display("FAIL rst_count got=%0d exp=0", fetch_count); end
    n_cmp++; if ({halted, fault} !== 2'b00) begin n_err++; $display("FAIL rst_flags got=%b exp=00", {halted, fault}); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    fetch_en = 1'b1; if_ready = 1'b1; #1;
    n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 32'h0) begin n_err++; $display("FAIL idle got v=%0b a=%h exp v=0 a=0", if_valid, imem_addr); end
    tick(); fetch_en = 1'b0; #1;
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'd0 || if_instr !== 32'hA500_0000) begin n_err++; $display("FAIL first got v=%0b pc=%0d i=%h exp v=1 pc=0 i=a5000000", if_valid, if_pc, if_instr); end
    n_cmp++; if (imem_addr !== 32'd1) begin n_err++; $display("FAIL first_addr got=%0d exp=1", imem_addr); end
    tick(); #1;
    n_cmp++; if (if_pc !== 32'd1 || if_instr !== 32'hA500_0001 || fetch_count !== 32'd1) begin n_err++; $display("FAIL second got pc=%0d i=%h c=%0d exp pc=1 i=a5000001 c=1", if_pc, if_instr, fetch_count); end
  endtask

  task automatic test_stall();
    tick(); if_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'd2 || if_instr !== 32'hA500_0002 || imem_addr !== 32'd2 || fetch_count !== 32'd2)
        begin n_err++; $display("FAIL stall%0d got v=%0b pc=%0d i=%h a=%0d c=%0d exp v=1 pc=2 i=a5000002 a=2 c=2", k, if_valid, if_pc, if_instr, imem_addr, fetch_count); end
      tick();
    end
    if_ready = 1'b1; #1;
    n_cmp++; if (if_pc !== 32'd2 || imem_addr !== 32'd3) begin n_err++; $display("FAIL stall_rel got pc=%0d a=%0d exp pc=2 a=3", if_pc, imem_addr); end
    tick(); #1;
    n_cmp++; if (if_pc !== 32'd3 || if_instr !== 32'hA500_0003) begin n_err++; $display("FAIL after_stall got pc=%0d i=%h exp pc=3 i=a5000003", if_pc, if_instr); end
    tick(); #1;
    n_cmp++; if (fetch_count !== 32'd4 || if_pc !== 32'd4) begin n_err++; $display("FAIL count4 got c=%0d pc=%0d exp c=4 pc=4", fetch_count, if_pc); end
  endtask

  task automatic test_redirect();
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
    n_cmp++; if (if_pc !== 32'd5 || if_valid !== 1'b0 || imem_addr !== 32'h40 || fetch_count !== 32'd5)
      begin n_err++; $display("FAIL redir got pc=%0d v=%0b a=%h c=%0d exp pc=5 v=0 a=40 c=5", if_pc, if_valid, imem_addr, fetch_count); end
    tick(); redirect_valid = 1'b0; if_ready = 1'b0; #1;
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== 32'hA500_0040 || fetch_count !== 32'd5)
      begin n_err++; $display("FAIL redir_tgt got v=%0b pc=%h i=%h c=%0d exp v=1 pc=40 i=a5000040 c=5", if_valid, if_pc, if_instr, fetch_count); end
    tick(); redirect_valid = 1'b1; redirect_pc = 32'h50; #1;
    n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 32'h50) begin n_err++; $display("FAIL redir_stall got v=%0b a=%h exp v=0 a=50", if_valid, imem_addr); end
    tick(); redirect_valid = 1'b0; if_ready = 1'b1; #1;
    n_cmp++; if (if_pc !== 32'h50 || if_valid !== 1'b1 || fetch_count !== 32'd5)
      begin n_err++; $display("FAIL redir_stall_tgt got pc=%h v=%0b c=%0d exp pc=50 v=1 c=5", if_pc, if_valid, fetch_count); end
  endtask

  task automatic test_halt();
    tick(); redirect_valid = 1'b1; redirect_pc = 32'd6; fetch_en = 1'b1; #1;
    n_cmp++; if (fetch_count !== 32'd6) begin n_err++; $display("FAIL pre_halt_count got=%0d exp=6", fetch_count); end
    tick(); redirect_valid = 1'b0; #1;
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'd6 || if_instr !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL halt_word got v=%0b pc=%0d i=%h exp v=1 pc=6 i=ffffffff", if_valid, if_pc, if_instr); end
    tick(); #1;
    n_cmp++; if (halted !== 1'b1 || if_valid !== 1'b0 || fetch_count !== 32'd7 || imem_addr !== 32'd6)
      begin n_err++; $display("FAIL halt got h=%0b v=%0b c=%0d a=%0d exp h=1 v=0 c=7 a=6", halted, if_valid, fetch_count, imem_addr); end
    tick(); #1;
    n_cmp++; if (halted !== 1'b1 || if_valid !== 1'b0) begin n_err++; $display("FAIL halt_hold got h=%0b v=%0b exp h=1 v=0", halted, if_valid); end
    fetch_en = 1'b0;
    tick(); #1;
    n_cmp++; if (halted !== 1'b0 || imem_addr !== 32'd0 || if_valid !== 1'b0) begin n_err++; $display("FAIL halt_idle got h=%0b a=%0d v=%0b exp h=0 a=0 v=0", halted, imem_addr, if_valid); end
    fetch_en = 1'b1;
    tick(); fetch_en = 1'b0; #1;
    n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'd0 || if_instr !== 32'hA500_0000) begin n_err++; $display("FAIL restart got v=%0b pc=%0d i=%h exp v=1 pc=0 i=a5000000", if_valid, if_pc, if_instr); end
  endtask

  task automatic test_bounds();
    tick(); redirect_valid = 1'b1; redirect_pc = 32'd1022;
    tick(); redirect_valid = 1'b0; #1;
    n_cmp++; if (if_pc !== 32'd1022 || fetch_count !== 32'd8) begin n_err++; $display("FAIL b1022 got pc=%0d c=%0d exp pc=1022 c=8", if_pc, fetch_count); end
    tick(); #1;
    n_cmp++; if (if_pc !== 32'd1023 || imem_addr !== 32'd1024) begin n_err++; $display("FAIL b1023 got pc=%0d a=%0d exp pc=1023 a=1024", if_pc, imem_addr); end
    tick(); #1;
    n_cmp++; if (fault !== 1'b1 || if_valid !== 1'b0 || fetch_count !== 32'd10 || imem_addr !== 32'd1024)
      begin n_err++; $display("FAIL b_fault got f=%0b v=%0b c=%0d a=%0d exp f=1 v=0 c=10 a=1024", fault, if_valid, fetch_count, imem_addr); end
    fetch_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'd0;
    tick(); tick(); #1;
    n_cmp++; if (fault !== 1'b1 || if_valid !== 1'b0) begin n_err++; $display("FAIL b_sticky got f=%0b v=%0b exp f=1 v=0", fault, if_valid); end
    fetch_en = 1'b0; redirect_valid = 1'b0;
    rst_n = 1'b0; #1;
    n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL b_rst_clear got=%0b exp=0", fault); end
    tick(); rst_n = 1'b1; fetch_en = 1'b1;
    tick(); fetch_en = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'd1024; #1;
    n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 32'd1024) begin n_err++; $display("FAIL b_redir got v=%0b a=%0d exp v=0 a=1024", if_valid, imem_addr); end
    tick(); redirect_valid = 1'b0; #1;
    n_cmp++; if (fault !== 1'b1 || if_valid !== 1'b0) begin n_err++; $display("FAIL b_redir_fault got f=%0b v=%0b exp f=1 v=0", fault, if_valid); end
  endtask

  task automatic test_async_reset();
    rst_n = 1'b0;
    tick(); rst_n = 1'b1; fetch_en = 1'b1; if_ready = 1'b1;
    tick(); fetch_en = 1'b0;
    tick(); if_ready = 1'b0; #1;
    n_cmp++; if (fetch_count !== 32'd1 || if_pc !== 32'd1 || if_valid !== 1'b1) begin n_err++; $display("FAIL ar_pre got c=%0d pc=%0d v=%0b exp c=1 pc=1 v=1", fetch_count, if_pc, if_valid); end
    tick(); #2;
    rst_n = 1'b0; #1;
    n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 32'd0 || fetch_count !== 32'd0 || if_pc !== 32'd0 || {halted, fault} !== 2'b00)
      begin n_err++; $display("FAIL ar_mid got v=%0b a=%0d c=%0d pc=%0d hf=%b exp v=0 a=0 c=0 pc=0 hf=00", if_valid, imem_addr, fetch_count, if_pc, {halted, fault}); end
    tick(); rst_n = 1'b1;
    tick(); #1;
    n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 32'd0) begin n_err++; $display("FAIL ar_idle got v=%0b a=%0d exp v=0 a=0", if_valid, imem_addr); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'hA500_0000 + 32'(i);
    rom[6] = 32'hFFFF_FFFF;
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_halt();
    test_bounds();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
